// File: rtl/sprite_rom_pkg.sv
// Shared sprite ROM constants and the read-tag type.
// Used by the arbiter, the image ROM wrapper and every requester.
// No ports: package only.
package sprite_rom_pkg;

  localparam int ROM_AW      = 14;  // {y[6:0], x[6:0]}
  localparam int ROM_DW      = 12;  // 4-bit R, G, B
  localparam int ROM_LATENCY = 1;   // ROM data appears one cycle after rom_addr
  localparam int ID_W        = 3;   // port id width, enough for 8 requesters

  // One stage to cover the rom_addr register plus one per ROM latency cycle.
  localparam int TAG_DEPTH   = ROM_LATENCY + 1;

  typedef struct packed {
    logic            vld;
    logic [ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/sprite_rom_arbiter_rr_pick.sv
// Round-robin picker: first requester at or above ptr_i, wrapping to the lowest index.
// Ports: req_i request vector, ptr_i search start index, win_o one-hot-or-zero winner.
// Purely combinational, no state, no backpressure.
module rr_pick
  import sprite_rom_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  ptr_i,
  output logic [N_REQ-1:0] win_o
);

  logic found;

  always_comb begin
    win_o = '0;
    found = 1'b0;
    // First pass: indices from ptr_i upward.
    for (int p = 0; p < N_REQ; p++) begin
      if (!found && req_i[p] && (ID_W'(p) >= ptr_i)) begin
        win_o[p] = 1'b1;
        found    = 1'b1;
      end
    end
    // Wrap-around pass: lowest requesting index below ptr_i.
    for (int p = 0; p < N_REQ; p++) begin
      if (!found && req_i[p]) begin
        win_o[p] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sprite_rom_arbiter.sv
// Sprite ROM arbiter: port 0 (display) has priority, ports 1..N-1 share round-robin,
// with a starvation cap on port-0 runs. Grant is combinational; read data returns
// on rdata/rvalid three cycles after the grant. Requesters hold req/addr until gnt.
// Ports: clk, rst_n (sync, active-low), req/addr in, gnt out, rdata/rvalid out,
// rom_addr out to the external single-port ROM, rom_rgb in from it.
module sprite_rom_arbiter
  import sprite_rom_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int AW         = ROM_AW,
  parameter int DW         = ROM_DW,
  parameter int STARVE_MAX = 15     // must be >= 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*AW-1:0] addr,
  output logic [N_REQ-1:0]    gnt,
  output logic [DW-1:0]       rdata,
  output logic [N_REQ-1:0]    rvalid,
  output logic [AW-1:0]       rom_addr,
  input  logic [DW-1:0]       rom_rgb
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic [AW-1:0]    rom_addr_q, rom_addr_d;
  logic [DW-1:0]    rdata_q, rdata_d;
  logic [N_REQ-1:0] rvalid_q, rvalid_d;
  tag_t             tag_q [TAG_DEPTH];
  tag_t             tag_in;

  logic             others;
  logic             force_rr;
  logic             accept;
  logic [N_REQ-1:0] rr_win;
  logic [N_REQ-1:0] gnt_c;
  logic [ID_W-1:0]  gnt_id;
  logic [AW-1:0]    gnt_addr;

  // Port 0 never enters the round-robin search, so bit 0 is forced low; with
  // rr_ptr in 1..N-1 the wrap pass then lands on port 1.
  rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
    .req_i ({req[N_REQ-1:1], 1'b0}),
    .ptr_i (rr_ptr_q),
    .win_o (rr_win)
  );

  always_comb begin
    others   = |req[N_REQ-1:1];
    force_rr = others && (starve_q == CNT_W'(STARVE_MAX));

    gnt_c = '0;
    if (!rst_n) begin
      gnt_c = '0;
    end else if (req[0] && !force_rr) begin
      gnt_c[0] = 1'b1;
    end else begin
      gnt_c = rr_win;  // zero when no secondary port requests
    end
    accept = |gnt_c;

    gnt_id   = '0;
    gnt_addr = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_c[i]) begin
        gnt_id   = ID_W'(i);
        gnt_addr = addr[i*AW +: AW];
      end
    end

    // Counts only port-0 grants that make someone else wait; anything else clears.
    starve_d = (gnt_c[0] && others) ? starve_q + CNT_W'(1) : '0;

    rr_ptr_d = rr_ptr_q;
    if (accept && !gnt_c[0]) begin
      rr_ptr_d = (gnt_id == ID_W'(N_REQ - 1)) ? ID_W'(1) : gnt_id + ID_W'(1);
    end

    rom_addr_d = accept ? gnt_addr : rom_addr_q;

    tag_in.vld = accept;
    tag_in.id  = gnt_id;

    for (int i = 0; i < N_REQ; i++) begin
      rvalid_d[i] = tag_q[TAG_DEPTH-1].vld && (tag_q[TAG_DEPTH-1].id == ID_W'(i));
    end
    rdata_d = tag_q[TAG_DEPTH-1].vld ? rom_rgb : rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q   <= ID_W'(1);
      starve_q   <= '0;
      rom_addr_q <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
      for (int s = 0; s < TAG_DEPTH; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      starve_q   <= starve_d;
      rom_addr_q <= rom_addr_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rvalid_d;
      tag_q[0]   <= tag_in;
      for (int s = 1; s < TAG_DEPTH; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  assign gnt      = gnt_c;
  assign rdata    = rdata_q;
  assign rvalid   = rvalid_q;
  assign rom_addr = rom_addr_q;

endmodule
